// File: rtl/rf_array_if.sv
// Register file access bundle: writeback write port, two read ports, ready flag.
// Ports: master = writeback/issue side, slave = rf_array.
// Read data comes back one cycle after the request; nothing is back-pressured.
interface rf_array_if #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // writeback write port
  logic                      rf_rd_we;
  logic [REG_ADDR_WIDTH-1:0] rf_rd_addr;
  logic [REG_WIDTH-1:0]      rf_rd;
  // read port 1
  logic                      rs1_req;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr;
  logic                      rs1_vld;
  logic [REG_WIDTH-1:0]      rs1_data;
  // read port 2
  logic                      rs2_req;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr;
  logic                      rs2_vld;
  logic [REG_WIDTH-1:0]      rs2_data;
  // array usable
  logic                      rf_rdy;

  modport master (
    output rf_rd_we, rf_rd_addr, rf_rd,
    output rs1_req, rs1_addr, rs2_req, rs2_addr,
    input  rs1_vld, rs1_data, rs2_vld, rs2_data, rf_rdy
  );

  modport slave (
    input  rf_rd_we, rf_rd_addr, rf_rd,
    input  rs1_req, rs1_addr, rs2_req, rs2_addr,
    output rs1_vld, rs1_data, rs2_vld, rs2_data, rf_rdy
  );
endinterface

// File: rtl/rf_array.sv
// Architectural integer register file: one write port, two registered read ports, x0 reads as zero.
// Latency: reads return 1 cycle after the request; init clears entries 1..DEPTH-1 one per cycle after reset.
// Backpressure: none; writes/reads accepted every cycle once rf_rdy is high, dropped while clearing.
// Ports: clk, rst (async, active-high), bus (rf_array_if.slave: write port, rs1/rs2 read ports, rf_rdy).
// Build option: define RF_BYPASS_EN to forward same-cycle write data to a colliding read.
module rf_array #(
  parameter int REG_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic      clk,
  input  logic      rst,
  rf_array_if.slave bus
);

  localparam int DEPTH = 1 << REG_ADDR_WIDTH;
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ONE  = REG_ADDR_WIDTH'(1);
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_LAST = '1;

  typedef enum logic {ST_INIT, ST_RDY} state_e;

  state_e                    state_q, state_d;
  logic [REG_ADDR_WIDTH-1:0] icnt_q, icnt_d;
  logic                      rs1_vld_q, rs1_vld_d;
  logic                      rs2_vld_q, rs2_vld_d;
  logic [REG_WIDTH-1:0]      rs1_data_q, rs1_data_d;
  logic [REG_WIDTH-1:0]      rs2_data_q, rs2_data_d;

  // Storage has no reset; entry 0 is never written and never read out.
  logic [REG_WIDTH-1:0]      mem_q [DEPTH];
  logic                      mem_we;
  logic [REG_ADDR_WIDTH-1:0] mem_waddr;
  logic [REG_WIDTH-1:0]      mem_wdata;

  logic                      rdy;
  logic [REG_WIDTH-1:0]      rs1_rdval, rs2_rdval;

  assign rdy = (state_q == ST_RDY);

  // Sequencer and the single array write port, shared by init clearing and writeback.
  always_comb begin
    state_d   = state_q;
    icnt_d    = icnt_q;
    mem_we    = 1'b0;
    mem_waddr = bus.rf_rd_addr;
    mem_wdata = bus.rf_rd;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = icnt_q;
        mem_wdata = '0;
        icnt_d    = icnt_q + ADDR_ONE;
        if (icnt_q == ADDR_LAST) begin
          state_d = ST_RDY;
        end
      end
      ST_RDY: begin
        mem_we = bus.rf_rd_we && (bus.rf_rd_addr != ADDR_ZERO);
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Read ports. mem_we in RDY already excludes x0, so x0 is never forwarded.
  always_comb begin
    rs1_rdval = mem_q[bus.rs1_addr];
    rs2_rdval = mem_q[bus.rs2_addr];
`ifdef RF_BYPASS_EN
    if (rdy && mem_we && (mem_waddr == bus.rs1_addr)) begin
      rs1_rdval = mem_wdata;
    end
    if (rdy && mem_we && (mem_waddr == bus.rs2_addr)) begin
      rs2_rdval = mem_wdata;
    end
`endif
    if (bus.rs1_addr == ADDR_ZERO) begin
      rs1_rdval = '0;
    end
    if (bus.rs2_addr == ADDR_ZERO) begin
      rs2_rdval = '0;
    end

    rs1_vld_d  = rdy && bus.rs1_req;
    rs2_vld_d  = rdy && bus.rs2_req;
    // Data holds its last value when no read is returned.
    rs1_data_d = rs1_vld_d ? rs1_rdval : rs1_data_q;
    rs2_data_d = rs2_vld_d ? rs2_rdval : rs2_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      icnt_q     <= ADDR_ONE;
      rs1_vld_q  <= 1'b0;
      rs2_vld_q  <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      icnt_q     <= icnt_d;
      rs1_vld_q  <= rs1_vld_d;
      rs2_vld_q  <= rs2_vld_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.rs1_vld  = rs1_vld_q;
  assign bus.rs2_vld  = rs2_vld_q;
  assign bus.rs1_data = rs1_data_q;
  assign bus.rs2_data = rs2_data_q;
  assign bus.rf_rdy   = rdy;

endmodule

// File: tb/tb_rf_array.sv
// Bench for rf_array: directed steps plus random traffic against a behavioural register-file model.
module tb_rf_array;

  logic clk;
  logic rst;

  rf_array_if #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) rf_bus ();

  rf_array #(.REG_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (rf_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: register contents, cycles of clearing left, expected read outputs.
  logic [31:0] model [32];
  int          init_left;
  logic        exp_v1, exp_v2;
  logic [31:0] exp_d1, exp_d2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    init_left = 31;
    exp_v1 = 1'b0;
    exp_v2 = 1'b0;
    exp_d1 = 32'h0;
    exp_d2 = 32'h0;
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (rf_bus.rf_rd_we && rf_bus.rf_rd_addr == a) return rf_bus.rf_rd;
`endif
    return model[a];
  endfunction

  // One clock: predict from current inputs, advance the model, compare 1ns after the edge.
  task automatic step();
    logic rdy;
    rdy = (init_left == 0);
    exp_v1 = rdy && rf_bus.rs1_req;
    exp_v2 = rdy && rf_bus.rs2_req;
    if (exp_v1) exp_d1 = ref_read(rf_bus.rs1_addr);
    if (exp_v2) exp_d2 = ref_read(rf_bus.rs2_addr);
    @(posedge clk);
    if (rdy && rf_bus.rf_rd_we && rf_bus.rf_rd_addr != 5'd0) model[rf_bus.rf_rd_addr] = rf_bus.rf_rd;
    if (!rdy) init_left--;
    #1;
    check("rf_rdy",   32'(rf_bus.rf_rdy),  32'(init_left == 0));
    check("rs1_vld",  32'(rf_bus.rs1_vld), 32'(exp_v1));
    check("rs2_vld",  32'(rf_bus.rs2_vld), 32'(exp_v2));
    check("rs1_data", rf_bus.rs1_data, exp_d1);
    check("rs2_data", rf_bus.rs2_data, exp_d2);
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r1, input logic [4:0] a1,
                       input logic r2, input logic [4:0] a2);
    rf_bus.rf_rd_we   = we;
    rf_bus.rf_rd_addr = wa;
    rf_bus.rf_rd      = wd;
    rf_bus.rs1_req    = r1;
    rf_bus.rs1_addr   = a1;
    rf_bus.rs2_req    = r2;
    rf_bus.rs2_addr   = a2;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},  32'(rf_bus.rf_rdy),  32'h0);
    check({tag, "_v1"},   32'(rf_bus.rs1_vld), 32'h0);
    check({tag, "_v2"},   32'(rf_bus.rs2_vld), 32'h0);
    check({tag, "_d1"},   rf_bus.rs1_data, 32'h0);
    check({tag, "_d2"},   rf_bus.rs2_data, 32'h0);
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    rst = 1'b1;
    rf_bus.rf_rd_we = 1'b0; rf_bus.rf_rd_addr = '0; rf_bus.rf_rd = '0;
    rf_bus.rs1_req  = 1'b0; rf_bus.rs1_addr   = '0;
    rf_bus.rs2_req  = 1'b0; rf_bus.rs2_addr   = '0;
    model_reset();

    // Reset values while held in reset
    @(posedge clk); @(posedge clk); #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Clearing phase; write x3 and read on both ports at cycle 5, all dropped
    idle(4);
    drive(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 1'b1, 5'd3);
    idle(26);
    check("rdy_after_31", 32'(rf_bus.rf_rdy), 32'h1);

    // Every register reads zero after clearing
    for (int a = 1; a < 32; a++) drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b0, 5'd0);
    idle(1);

    // Write then dual-port read of same register
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    check("x5_rs1", rf_bus.rs1_data, 32'hDEADBEEF);
    check("x5_rs2", rf_bus.rs2_data, 32'hDEADBEEF);

    // x0 ignores writes
    drive(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    check("x0_rs1", rf_bus.rs1_data, 32'h0);

    // Read/write collision on x7
    drive(1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b1, 5'd7, 32'h22, 1'b1, 5'd7, 1'b0, 5'd0);
`ifdef RF_BYPASS_EN
    check("coll_rs1", rf_bus.rs1_data, 32'h22);
`else
    check("coll_rs1", rf_bus.rs1_data, 32'h11);
`endif
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1, 5'd7);
    check("coll_rs2", rf_bus.rs2_data, 32'h22);
    idle(2);

    // Random traffic on a small address window to provoke collisions
    random_traffic(300);

    // Mid-traffic reset: read in flight is lost, outputs clear asynchronously
    drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b0, 5'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    check("x9_pre", rf_bus.rs1_data, 32'h55);
    rf_bus.rs1_req = 1'b1; rf_bus.rs1_addr = 5'd9;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(31);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
    check("x9_post", rf_bus.rs1_data, 32'h0);

    random_traffic(150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
